// File: rtl/cam_pixel_capture_pkg.sv
// cam_pixel_capture_pkg: shared widths and FSM state encodings for the camera capture path
package cam_pixel_capture_pkg;
    localparam int ADDR_W = 17;
    localparam int PIX_W  = 12;
    localparam int BYTE_W = 8;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_VS = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;
endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: multi-flop synchronizer with registered-history rise/fall detect
// Ports: clk, reset (async active-low), d (async input), q (synchronized level),
//        rise/fall (one-clk pulses on synchronized transitions)
module cam_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sr;
    logic prev;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sr   <= '0;
            prev <= 1'b0;
        end else begin
            sr   <= {sr[SYNC_STAGES-2:0], d};
            prev <= sr[SYNC_STAGES-1];
        end
    assign q    = sr[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: samples an 8-bit camera bus and packs byte pairs into RGB444 pixel writes
// Ports: clk, reset (async active-low); cam_pclk/cam_vsync/cam_href/cam_data camera bus;
//        capture_en level enable; addr_out/data_out/WE pixel write (addr bit 16 = overflow);
//        frame_active high during a captured frame; frame_done one-clk end-of-frame pulse
module cam_pixel_capture
    import cam_pixel_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_LIMIT  = 65536,
    parameter bit HI_FIRST    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [BYTE_W-1:0] cam_data,
    input  logic              capture_en,
    output logic [ADDR_W-1:0] addr_out,
    output logic [PIX_W-1:0]  data_out,
    output logic              WE,
    output logic              frame_active,
    output logic              frame_done
);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ADDR_LIMIT);
    logic pclk_q, pclk_rise, pclk_fall;
    logic vs_q, vs_rise, vs_fall;
    logic href_q, href_rise, href_fall;
    logic unused_ok;
    logic [BYTE_W-1:0] dly [SYNC_STAGES];
    logic [BYTE_W-1:0] byte_q, byte0;
    logic [PIX_W-1:0]  pix;
    logic [ADDR_W-1:0] cnt;
    logic [1:0] state;
    logic phase, ph, take, pix_valid, done_pend;

    cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pclk (
        .clk(clk), .reset(reset), .d(cam_pclk), .q(pclk_q), .rise(pclk_rise), .fall(pclk_fall)
    );
    cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vsync (
        .clk(clk), .reset(reset), .d(cam_vsync), .q(vs_q), .rise(vs_rise), .fall(vs_fall)
    );
    cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_href (
        .clk(clk), .reset(reset), .d(cam_href), .q(href_q), .rise(href_rise), .fall(href_fall)
    );
    assign unused_ok = ^{pclk_q, pclk_fall, vs_q, href_fall};

    // data takes the same number of flops as the controls so a byte lines up with its pclk edge
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) dly[i] <= '0;
        end else begin
            dly[0] <= cam_data;
            for (int i = 1; i < SYNC_STAGES; i++) dly[i] <= dly[i-1];
        end
    assign byte_q = dly[SYNC_STAGES-1];

    // an href rising edge restarts pairing even if it coincides with the first byte's edge
    assign ph   = href_rise ? 1'b0 : phase;
    assign take = (state == ACTIVE) && pclk_rise && href_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= IDLE;
            phase        <= 1'b0;
            byte0        <= '0;
            pix          <= '0;
            pix_valid    <= 1'b0;
            done_pend    <= 1'b0;
            cnt          <= '0;
            addr_out     <= '0;
            data_out     <= '0;
            WE           <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            pix_valid  <= take && ph;
            // frame end goes through one extra stage so it lines up with the last pixel's WE
            done_pend  <= (state == ACTIVE) && vs_rise;
            frame_done <= done_pend;
            WE         <= 1'b0;
            if (take) phase <= ~ph;
            else if (href_rise) phase <= 1'b0;
            if (take && !ph) byte0 <= byte_q;
            if (take && ph) pix <= HI_FIRST ? {byte0[3:0], byte_q} : {byte_q[3:0], byte0};
            if (done_pend) frame_active <= 1'b0;
            if (state == IDLE) begin
                if (capture_en) state <= WAIT_VS;
            end else if (state == WAIT_VS) begin
                if (!capture_en) state <= IDLE;
                else if (vs_fall) begin
                    state        <= ACTIVE;
                    frame_active <= 1'b1;
                    cnt          <= '0;
                end
            end else if (vs_rise) begin
                state <= capture_en ? WAIT_VS : IDLE;
            end
            if (pix_valid) begin
                if (cnt < LIMIT) begin
                    WE       <= 1'b1;
                    addr_out <= cnt;
                    data_out <= pix;
                    cnt      <= cnt + 1'b1;
                end else begin
                    addr_out <= LIMIT;
                end
            end
        end
endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb_cam_pixel_capture: directed bench for cam_pixel_capture (default, ADDR_LIMIT=8, HI_FIRST=0)
module tb_cam_pixel_capture;
    logic clk = 1'b0;
    logic reset, cam_pclk, cam_vsync, cam_href, capture_en;
    logic [7:0] cam_data;
    logic [16:0] addr_a, addr_l, addr_h;
    logic [11:0] data_a, data_l, data_h;
    logic we_a, we_l, we_h, fa_a, fa_l, fa_h, fd_a, fd_l, fd_h;
    logic [28:0] qa[$], ql[$], qh[$];
    logic [7:0] lb[$];
    int checks = 0, errors = 0;
    int fd_cnt_a = 0, fd_cnt_h = 0;
    logic fa_seen = 1'b0, co_h = 1'b0;

    always #5 clk = ~clk;

    cam_pixel_capture dut_a (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .addr_out(addr_a), .data_out(data_a),
        .WE(we_a), .frame_active(fa_a), .frame_done(fd_a)
    );
    cam_pixel_capture #(.ADDR_LIMIT(8)) dut_l (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .addr_out(addr_l), .data_out(data_l),
        .WE(we_l), .frame_active(fa_l), .frame_done(fd_l)
    );
    cam_pixel_capture #(.HI_FIRST(1'b0)) dut_h (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .addr_out(addr_h), .data_out(data_h),
        .WE(we_h), .frame_active(fa_h), .frame_done(fd_h)
    );

    always @(negedge clk) begin
        if (we_a) qa.push_back({addr_a, data_a});
        if (we_l) ql.push_back({addr_l, data_l});
        if (we_h) qh.push_back({addr_h, data_h});
        if (fd_a) fd_cnt_a++;
        if (fd_h) fd_cnt_h++;
        if (fa_a) fa_seen = 1'b1;
        if (we_h && fd_h) co_h = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic vs_high();
        cam_vsync = 1'b1;
        #200;
    endtask

    task automatic vs_low();
        cam_vsync = 1'b0;
        #200;
    endtask

    task automatic line();
        cam_href = 1'b1;
        for (int i = 0; i < lb.size(); i++) begin
            cam_data = lb[i];
            cam_pclk = 1'b0;
            #40;
            cam_pclk = 1'b1;
            #40;
        end
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        #160;
    endtask

    initial begin
        reset = 1'b0;
        cam_pclk = 1'b0;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        cam_data = 8'h00;
        capture_en = 1'b1;
        #102;
        check("rst_addr", 32'(addr_a), 32'h0);
        check("rst_data", 32'(data_a), 32'h0);
        check("rst_we", 32'(we_a), 32'h0);
        check("rst_fa", 32'(fa_a), 32'h0);
        check("rst_fd", 32'(fd_a), 32'h0);
        reset = 1'b1;

        vs_high();
        vs_low();
        lb = '{8'h0A, 8'hBC, 8'h01, 8'h23};
        line();
        check("t1_count", 32'(qa.size()), 32'd2);
        check("t1_px0", 32'(qa[0]), 32'h0ABC);
        check("t1_px1", 32'(qa[1]), 32'h1123);
        check("t1_active", 32'(fa_a), 32'h1);
        check("t1_fd_before", 32'(fd_cnt_a), 32'd0);
        vs_high();
        check("t1_fd_after", 32'(fd_cnt_a), 32'd1);
        check("t1_inactive", 32'(fa_a), 32'h0);

        capture_en = 1'b0;
        #20;
        qa.delete();
        fa_seen = 1'b0;
        vs_low();
        line();
        vs_high();
        vs_low();
        check("t2_off_we", 32'(qa.size()), 32'd0);
        check("t2_off_fa", 32'(fa_seen), 32'h0);
        capture_en = 1'b1;
        line();
        check("t2_midframe_we", 32'(qa.size()), 32'd0);
        vs_high();
        vs_low();
        lb = '{8'h0A, 8'hBC};
        line();
        check("t2_count", 32'(qa.size()), 32'd1);
        check("t2_px0", 32'(qa[0]), 32'h0ABC);

        vs_high();
        qa.delete();
        vs_low();
        lb = '{8'h0F, 8'hFF, 8'h05};
        line();
        lb = '{8'h12, 8'h34};
        line();
        check("t3_count", 32'(qa.size()), 32'd2);
        check("t3_px0", 32'(qa[0]), 32'h0FFF);
        check("t3_px1", 32'(qa[1]), 32'h1234);

        vs_high();
        ql.delete();
        vs_low();
        lb.delete();
        for (int i = 0; i < 10; i++) begin
            lb.push_back(8'(i));
            lb.push_back(8'h55);
        end
        line();
        check("t4_count", 32'(ql.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t4_px%0d", i), 32'(ql[i]), 32'((i << 12) | (i << 8) | 8'h55));
        check("t4_sat_addr", 32'(addr_l), 32'h8);
        vs_high();
        ql.delete();
        vs_low();
        lb = '{8'h0A, 8'hBC};
        line();
        check("t4_restart_count", 32'(ql.size()), 32'd1);
        check("t4_restart_px", 32'(ql[0]), 32'h0ABC);

        vs_high();
        vs_low();
        lb = '{8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h04, 8'h44, 8'h05, 8'h55};
        line();
        check("t5_pre_addr", 32'(addr_a), 32'h4);
        check("t5_pre_data", 32'(data_a), 32'h555);
        reset = 1'b0;
        #2;
        check("t5_addr", 32'(addr_a), 32'h0);
        check("t5_data", 32'(data_a), 32'h0);
        check("t5_fa", 32'(fa_a), 32'h0);
        check("t5_we", 32'(we_a), 32'h0);
        #48;
        reset = 1'b1;
        qa.delete();
        line();
        check("t5_no_we", 32'(qa.size()), 32'd0);
        vs_high();
        vs_low();
        lb = '{8'h0A, 8'hBC};
        line();
        check("t5_count", 32'(qa.size()), 32'd1);
        check("t5_px0", 32'(qa[0]), 32'h0ABC);

        vs_high();
        qa.delete();
        qh.delete();
        fd_cnt_h = 0;
        co_h = 1'b0;
        vs_low();
        cam_href = 1'b1;
        cam_data = 8'hBC;
        cam_pclk = 1'b0;
        #40;
        cam_pclk = 1'b1;
        #40;
        cam_data = 8'h0A;
        cam_pclk = 1'b0;
        #40;
        cam_pclk = 1'b1;
        cam_vsync = 1'b1;
        #40;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        #200;
        check("t6_count", 32'(qh.size()), 32'd1);
        check("t6_px0", 32'(qh[0]), 32'h0ABC);
        check("t6_hi_first_px", 32'(qa[0]), 32'h0C0A);
        check("t6_fd", 32'(fd_cnt_h), 32'd1);
        check("t6_same_cycle", 32'(co_h), 32'h1);
        check("t6_inactive", 32'(fa_h), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
Upstream feeder for capture_buff. Samples an OV7670-style 8-bit camera bus (PCLK/VSYNC/HREF/D[7:0]) in the system clock domain and packs byte pairs into 12-bit RGB444 pixels. Generates a 17-bit frame-relative write address and a one-cycle WE strobe per pixel. Address bit 16 is the overflow indication that capture_buff consumes.

Parameters:
SYNC_STAGES, 2, flops in each camera-input synchronizer (minimum 2)
ADDR_LIMIT, 65536, pixel count at which the address saturates (maximum 65536)
HI_FIRST, 1, 1 = first byte of a pair carries R in bits [3:0]; 0 = first byte carries G/B

Ports:
clk  input  1  system clock; must run at least 4x cam_pclk
reset  input  1  asynchronous, active-low reset
cam_pclk  input  1  camera pixel clock, asynchronous to clk
cam_vsync  input  1  high = vertical blank
cam_href  input  1  high = valid line bytes
cam_data  input  8  camera byte bus
capture_en  input  1  level; frames are captured while high
addr_out  output  17  pixel write address; bit 16 set = overflow
data_out  output  12  pixel {R[3:0],G[3:0],B[3:0]}
WE  output  1  one-clk strobe; addr_out/data_out are valid with it
frame_active  output  1  high while a frame is being captured
frame_done  output  1  one-clk pulse at end of a captured frame

Behaviour:
- Reset values: addr_out=0, data_out=0, WE=0, frame_active=0, frame_done=0, FSM=IDLE, byte phase=0, pixel counter=0.
- Synchronization: cam_pclk, cam_vsync and cam_href each pass through SYNC_STAGES flops. cam_data is delayed by the same number of stages so it stays aligned with them.
- PCLK rising edge = synchronized pclk was 0 last cycle and is 1 this cycle. All byte sampling happens only in edge cycles.
- FSM:
  - IDLE: go to WAIT_VS when capture_en=1.
  - WAIT_VS: go to ACTIVE on a synchronized vsync falling edge. Set frame_active=1 and clear the pixel counter. If capture_en drops while here, return to IDLE.
  - ACTIVE: capture bytes. On a vsync rising edge, pulse frame_done for 1 clk, set frame_active=0, and go to WAIT_VS (or to IDLE if capture_en=0). Dropping capture_en mid-frame does not abort the current frame.
- Byte packing:
  - Byte phase resets to 0 on every href rising edge.
  - On a pclk edge with href=1 and phase 0, latch byte 0 and set phase=1.
  - On a pclk edge with href=1 and phase 1, complete the pixel and set phase=0.
  - HI_FIRST=1: pixel = {byte0[3:0], byte1[7:0]}. HI_FIRST=0: pixel = {byte1[3:0], byte0[7:0]}.
- Pixel write (the clk cycle after the completing edge):
  - If counter < ADDR_LIMIT: data_out<=pixel, addr_out<=counter, WE<=1 for exactly 1 clk, counter<=counter+1.
  - If counter == ADDR_LIMIT: no WE, addr_out<=ADDR_LIMIT (bit 16 set at default), counter holds.
- Latency: WE asserts SYNC_STAGES+2 clk after the raw cam_pclk rising edge of byte 1.
- Stability: addr_out and data_out hold between strobes, i.e. at least 2 pclk periods, which covers capture_buff's SRAM handshake.
- Partial pixels: if href falls with phase=1, the orphan byte is discarded and no WE is issued. The address continues from the next whole pixel.
- Simultaneous events: a vsync rising edge in the same cycle as a completing pixel still writes that pixel, and frame_done asserts in the same cycle as its WE.
- Reset mid-frame clears all state. Capture never begins mid-frame; the block always waits for the next vsync falling edge.
- Address arithmetic is 17-bit unsigned, with no wrap-around. The counter advances only on WE.

Decomposition:
- Shared package: FSM state encodings (IDLE, WAIT_VS, ACTIVE), ADDR_W=17, PIX_W=12, BYTE_W=8.
- One sub-module, cam_sync_edge: parameterized SYNC_STAGES synchronizer plus rise/fall edge detect. It is instantiated for pclk, vsync and href, and the data delay line lives beside it.

Test Plan:
1. Reset, capture_en=1, vsync pulse, one line of bytes 0x0A,0xBC,0x01,0x23 -> two WE pulses: addr 0 data 0xABC, then addr 1 data 0x123. frame_done pulses on the next vsync rise.
2. capture_en=0 for a full frame -> no WE, frame_active stays 0. Raise capture_en mid-frame -> no WE until after the next vsync falling edge.
3. Line of 3 bytes (href drops after 0x0F,0xFF,0x05) -> one WE (addr 0, 0xFFF), orphan 0x05 dropped. Next line's first pixel uses addr 1.
4. ADDR_LIMIT=8, frame of 10 pixels -> 8 WE pulses at addr 0..7, then addr_out=8 held with no further WE. The next frame restarts at addr 0.
5. Assert reset after 5 pixels -> all outputs return to 0 immediately. After release, no WE until a vsync falling edge, and the first address is then 0.
6. HI_FIRST=0, bytes 0xBC,0x0A -> data_out=0xABC. A vsync rise coinciding with a pixel completion gives WE and frame_done in the same cycle.
